// File: rtl/i2s_dac_tx.sv
// I2S DAC serializer: takes parallel left/right samples from the synth engine
// and shifts them out MSB-first in standard I2S framing (one BCLK delay after
// the LRCK edge). A holding register decouples sample arrival from frame
// timing. When no fresh pair has arrived, the last pair is repeated and the
// underrun is flagged and counted.
module i2s_dac_tx #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int SLOT_BITS     = 32,
    parameter int BCLK_DIV      = 4
) (
    input  logic                            AUDIO_CLK,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            sample_valid,
    input  logic signed [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic signed [AUD_BIT_DEPTH-1:0] rsound_in,
    output logic                            trig,
    output logic                            AUD_BCLK,
    output logic                            AUD_DACLRCK,
    output logic                            AUD_DACDAT,
    output logic                            underrun,
    output logic [7:0]                      underrun_cnt
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0]                div_cnt;
    logic [BIT_W-1:0]                bit_cnt;
    logic signed [AUD_BIT_DEPTH-1:0] hold_l;
    logic signed [AUD_BIT_DEPTH-1:0] hold_r;
    logic signed [AUD_BIT_DEPTH-1:0] frame_l;
    logic signed [AUD_BIT_DEPTH-1:0] frame_r;
    logic                            fresh;

    logic                            load;
    logic                            bclk_nxt;
    logic                            lrck_nxt;
    logic                            dat_nxt;
    logic [BIT_W-1:0]                slot_k;
    logic signed [AUD_BIT_DEPTH-1:0] slot_word;

    // Saturating increment for the underrun counter: sticks at all-ones.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Serial bit for slot position k: word MSB at k=1, zero padding elsewhere.
    function automatic logic slot_bit(input logic [AUD_BIT_DEPTH-1:0] w,
                                      input logic [BIT_W-1:0] k);
        logic b;
        b = 1'b0;
        for (int j = 0; j < AUD_BIT_DEPTH; j++) begin
            if (k == BIT_W'(AUD_BIT_DEPTH - j)) b = w[j];
        end
        return b;
    endfunction

    // Frame load strobe and next serial output values from the current counters.
    always_comb begin
        load      = enable && (div_cnt == '0) && (bit_cnt == '0);
        bclk_nxt  = (div_cnt >= DIV_HALF);
        lrck_nxt  = (bit_cnt >= SLOT);
        slot_k    = lrck_nxt ? (bit_cnt - SLOT) : bit_cnt;
        slot_word = lrck_nxt ? frame_r : frame_l;
        dat_nxt   = slot_bit(slot_word, slot_k);
    end

    // BCLK divider and frame bit counter; held at zero while idle.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset || !enable) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Sample capture into the holding register and frame load; a capture
    // coincident with a load still lands in hold and keeps fresh set.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset) begin
            hold_l       <= '0;
            hold_r       <= '0;
            frame_l      <= '0;
            frame_r      <= '0;
            fresh        <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            if (sample_valid) begin
                hold_l <= lsound_in;
                hold_r <= rsound_in;
            end
            if (load) begin
                frame_l <= hold_l;
                frame_r <= hold_r;
                if (!fresh) underrun_cnt <= sat_inc(underrun_cnt);
            end
            if (sample_valid) fresh <= 1'b1;
            else if (load)    fresh <= 1'b0;
        end
    end

    // Registered serial outputs and per-frame strobes, forced low when idle.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset || !enable) begin
            trig        <= 1'b0;
            underrun    <= 1'b0;
            AUD_BCLK    <= 1'b0;
            AUD_DACLRCK <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else begin
            trig        <= load;
            underrun    <= load && !fresh;
            AUD_BCLK    <= bclk_nxt;
            AUD_DACLRCK <= lrck_nxt;
            AUD_DACDAT  <= dat_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: frame framing, data serialization, underrun
// repeat/counting, coincident capture, saturation, enable drop and reset abort.
module tb_i2s_dac_tx;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               sample_valid;
    logic signed [23:0] lsound_in;
    logic signed [23:0] rsound_in;
    logic               trig;
    logic               AUD_BCLK;
    logic               AUD_DACLRCK;
    logic               AUD_DACDAT;
    logic               underrun;
    logic [7:0]         underrun_cnt;

    int n_cmp = 0;
    int n_err = 0;

    i2s_dac_tx #(.AUD_BIT_DEPTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
        .AUDIO_CLK   (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_valid(sample_valid),
        .lsound_in   (lsound_in),
        .rsound_in   (rsound_in),
        .trig        (trig),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " bclk"}, 32'(AUD_BCLK), 0);
        check({tag, " lrck"}, 32'(AUD_DACLRCK), 0);
        check({tag, " dat"},  32'(AUD_DACDAT), 0);
        check({tag, " trig"}, 32'(trig), 0);
        check({tag, " ur"},   32'(underrun), 0);
    endtask

    // Called at the observation point just after a load edge (i=0); returns at
    // i=0 of the following frame. Optional sample_valid pulses at i=at0/at1.
    task automatic run_frame(input string nm, input logic [23:0] el, input logic [23:0] er,
                             input logic eur, input logic [7:0] ecnt,
                             input int at0, input logic [23:0] l0, input logic [23:0] r0,
                             input int at1, input logic [23:0] l1, input logic [23:0] r1);
        logic [23:0] rxl, rxr, w;
        logic        e;
        int          k;
        rxl = '0;
        rxr = '0;
        for (int i = 0; i < 256; i++) begin
            k = (i / 4) % 32;
            w = (i >= 128) ? er : el;
            e = 1'b0;
            if (k >= 1 && k <= 24) e = w[24-k];
            check($sformatf("%s bclk i%0d", nm, i), 32'(AUD_BCLK), ((i % 4) >= 2) ? 1 : 0);
            check($sformatf("%s lrck i%0d", nm, i), 32'(AUD_DACLRCK), (i >= 128) ? 1 : 0);
            check($sformatf("%s dat i%0d", nm, i), 32'(AUD_DACDAT), 32'(e));
            check($sformatf("%s trig i%0d", nm, i), 32'(trig), (i == 0) ? 1 : 0);
            check($sformatf("%s ur i%0d", nm, i), 32'(underrun), (i == 0 && eur) ? 1 : 0);
            if (i == 0) check({nm, " ucnt"}, 32'(underrun_cnt), 32'(ecnt));
            if ((i % 4) == 2 && k >= 1 && k <= 24) begin
                if (i >= 128) rxr = {rxr[22:0], AUD_DACDAT};
                else          rxl = {rxl[22:0], AUD_DACDAT};
            end
            sample_valid = (i == at0) || (i == at1);
            if (i == at0) begin lsound_in = l0; rsound_in = r0; end
            if (i == at1) begin lsound_in = l1; rsound_in = r1; end
            tick();
        end
        sample_valid = 1'b0;
        check({nm, " rx left"},  32'(rxl), 32'(el));
        check({nm, " rx right"}, 32'(rxr), 32'(er));
    endtask

    logic [7:0] cnt_m;

    initial begin
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        lsound_in = '0; rsound_in = '0;
        tick(); tick();
        check_idle("reset");
        check("reset ucnt", 32'(underrun_cnt), 0);

        // Capture the first pair before enabling; first enabled edge loads it.
        reset = 1'b0;
        tick();
        sample_valid = 1'b1; lsound_in = 24'hA5A5A5; rsound_in = 24'h5A5A5A;
        tick();
        sample_valid = 1'b0;
        enable = 1'b1;
        tick();
        run_frame("f1", 24'hA5A5A5, 24'h5A5A5A, 1'b0, 8'd0, -1, 0, 0, -1, 0, 0);

        // Starved frames repeat the pair and count underruns.
        run_frame("f2", 24'hA5A5A5, 24'h5A5A5A, 1'b1, 8'd1, -1, 0, 0, -1, 0, 0);
        run_frame("f3", 24'hA5A5A5, 24'h5A5A5A, 1'b1, 8'd2, -1, 0, 0, -1, 0, 0);
        run_frame("f4", 24'hA5A5A5, 24'h5A5A5A, 1'b1, 8'd3, -1, 0, 0, -1, 0, 0);

        // Fresh 7FFFFF mid-frame, then a new pair exactly on the next load edge.
        run_frame("f5", 24'hA5A5A5, 24'h5A5A5A, 1'b1, 8'd4,
                  10, 24'h7FFFFF, 24'h800000, 255, 24'h000001, 24'hFFFFFF);
        run_frame("f6", 24'h7FFFFF, 24'h800000, 1'b0, 8'd4, -1, 0, 0, -1, 0, 0);
        run_frame("f7", 24'h000001, 24'hFFFFFF, 1'b0, 8'd4, -1, 0, 0, -1, 0, 0);

        // Long starvation: counter saturates, pulse keeps firing.
        cnt_m = 8'd4;
        for (int f = 0; f < 300; f++) begin
            cnt_m = (cnt_m == 8'hFF) ? cnt_m : cnt_m + 8'd1;
            check($sformatf("starve ur f%0d", f), 32'(underrun), 1);
            check($sformatf("starve ucnt f%0d", f), 32'(underrun_cnt), 32'(cnt_m));
            tick();
            check($sformatf("starve ur low f%0d", f), 32'(underrun), 0);
            repeat (255) tick();
        end
        check("sat ucnt", 32'(underrun_cnt), 255);
        check("sat ur", 32'(underrun), 1);

        // Drop enable at bit_cnt=40 (right slot, BCLK high half).
        repeat (161) tick();
        check("pre-drop lrck", 32'(AUD_DACLRCK), 1);
        enable = 1'b0;
        tick();
        check_idle("drop");
        repeat (5) tick();
        check_idle("idle");
        check("idle ucnt", 32'(underrun_cnt), 255);
        enable = 1'b1;
        tick();
        run_frame("reen", 24'h000001, 24'hFFFFFF, 1'b1, 8'd255, -1, 0, 0, -1, 0, 0);

        // One-cycle reset in the middle of the right slot.
        repeat (150) tick();
        check("pre-reset lrck", 32'(AUD_DACLRCK), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid reset");
        check("mid reset ucnt", 32'(underrun_cnt), 0);
        tick();
        run_frame("post", 24'h000000, 24'h000000, 1'b1, 8'd1, -1, 0, 0, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
Audio output serializer that sits directly downstream of the synthesizer top. It consumes the parallel 24-bit left and right samples (lsound_out/rsound_out) plus the engine's cycle-complete strobe (xxxx_zero). It generates the codec bit clock, word clock and serial data in standard I2S format, and issues the per-frame trig pulse back to the synth engine. Holding-register handshake with repeat-on-underrun and a saturating underrun counter.

Parameters:
AUD_BIT_DEPTH  24  sample width, MSB-first
SLOT_BITS  32  BCLK periods per channel slot; must be >= AUD_BIT_DEPTH+1
BCLK_DIV  4  AUDIO_CLK cycles per BCLK period; even, >= 2

Ports:
AUDIO_CLK  in  1  sole clock; all logic on its rising edge
reset  in  1  synchronous, active-high
enable  in  1  run serializer; low = idle and counters cleared
sample_valid  in  1  one-cycle strobe, new sample pair present (from xxxx_zero)
lsound_in  in  AUD_BIT_DEPTH  left sample, two's complement
rsound_in  in  AUD_BIT_DEPTH  right sample, two's complement
trig  out  1  one-cycle pulse per frame, request next sample pair
AUD_BCLK  out  1  I2S bit clock
AUD_DACLRCK  out  1  word clock, 0 = left, 1 = right
AUD_DACDAT  out  1  serial data
underrun  out  1  one-cycle pulse, frame started without a fresh sample
underrun_cnt  out  8  saturating underrun count

Behaviour:
- Clock and reset are fixed: one clock, AUDIO_CLK; reset is synchronous and active-high.
- Reset: div_cnt=0, bit_cnt=0, hold_l/hold_r=0, frame_l/frame_r=0, fresh=0, underrun_cnt=0.
- Reset: all outputs 0 on the cycle after reset is sampled high.
- Reset mid-frame aborts the frame immediately. No partial-frame completion.
- Counters while enable=1:
  - div_cnt counts 0..BCLK_DIV-1, then wraps.
  - bit_cnt counts 0..2*SLOT_BITS-1 and advances when div_cnt wraps.
- enable=0: both counters are forced to 0 and no load, trig or underrun occurs. Sample capture still operates.
- Frame load event: enable=1 && div_cnt==0 && bit_cnt==0.
  - Consequence: the first enabled cycle after idle or reset is a load.
  - Frame period = 2*SLOT_BITS*BCLK_DIV cycles (default 256).
- Capture: on sample_valid, hold_l<=lsound_in, hold_r<=rsound_in, fresh<=1.
- On load: frame_l<=hold_l and frame_r<=hold_r. Then:
  - if fresh==0: pulse underrun and increment underrun_cnt, saturating at 255; hold is reused, so the last sample repeats.
  - clear fresh, unless sample_valid is high in the same cycle.
- sample_valid coincident with load:
  - the load takes the old hold contents, with underrun judged on the old fresh;
  - the new pair is captured and fresh=1 for the next frame.
- trig and underrun are registered and asserted for exactly the one cycle after the load event.
- Output mapping: all serial outputs are registered and reflect the counter state (div_cnt, bit_cnt) of the previous cycle.
  - AUD_BCLK = (div_cnt >= BCLK_DIV/2). The low half comes first, so data changes on the BCLK falling edge and the codec samples on the rising edge.
  - AUD_DACLRCK = (bit_cnt >= SLOT_BITS).
  - Slot bit k = bit_cnt mod SLOT_BITS; word = frame_l in the left slot, frame_r in the right slot.
  - AUD_DACDAT = word[AUD_BIT_DEPTH-k] for 1 <= k <= AUD_BIT_DEPTH, else 0. This gives the standard I2S one-BCLK delay after the LRCK edge, MSB first, with zero padding.
- enable falling mid-frame: outputs 0 on the next cycle. Re-enable restarts at a load (left slot).
- No arithmetic on sample data: bits pass through unaltered.

Test Plan:
- Reset, enable=1, sample_valid with L=0xA5A5A5, R=0x5A5A5A before the first load -> first frame (starting at the first load):
  - LRCK low for 32 BCLKs, then high for 32;
  - DACDAT slot bits 1..24 = 0xA5A5A5 (left) / 0x5A5A5A (right), MSB first; bits 0 and 25..31 = 0;
  - BCLK period 4 cycles; trig every 256 cycles.
- No sample_valid for 3 consecutive frames after a fresh pair -> the same pair is repeated each frame; underrun pulses 3 times; underrun_cnt=3.
- sample_valid (L=0x000001) in the exact load cycle, with fresh=1 holding L=0x7FFFFF:
  - current frame sends 0x7FFFFF with no underrun;
  - next frame sends 0x000001 with no underrun.
- Starve for 300 frames -> underrun_cnt holds at 255 and the underrun pulse continues every frame.
- Drop enable at bit_cnt=40 -> BCLK, LRCK and DACDAT are 0 on the next cycle. Re-enable -> trig one cycle later and the left slot restarts from bit 0.
- Assert reset for 1 cycle mid right slot -> next cycle all outputs 0 and underrun_cnt=0. The first post-reset frame sends zeros and counts 1 underrun.
